// File: rtl/frame_pkg.sv
// Shared constants and state encodings for the framed serial receiver.
package frame_pkg;
  localparam logic [7:0] HDR0   = 8'hAA;
  localparam logic [7:0] HDR1   = 8'h0D;
  localparam int         PAYLEN = 4;

  localparam logic [1:0] RC_STOP = 2'b01;
  localparam logic [1:0] RC_HDR  = 2'b10;
  localparam logic [1:0] RC_TO   = 2'b11;

  typedef enum logic [1:0] {P_HUNT, P_HDR, P_PAY} pstate_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rstate_e;
endpackage

// File: rtl/frame_rx_if.sv
// Serial line in, frame results out; master drives the line, slave is the receiver.
interface frame_rx_if;
  logic        Rx;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rerr;
  logic [1:0]  rcode;
  logic        busy;

  modport master (output Rx, input rdata, rvalid, rerr, rcode, busy);
  modport slave  (input Rx, output rdata, rvalid, rerr, rcode, busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 16x oversampling byte receiver: 2-flop sync, free-running tick, start/data/stop sampling.
// Byte is presented one ck after the stop sample; no backpressure.
module uart_rx_byte
  import frame_pkg::*;
#(
  parameter int CLK_DIV = 27
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       bvalid_o,
  output logic       serr_o,
  output logic       idle_o,
  output logic       start_o,
  output logic       tick_o
);
  localparam int TW = $clog2(CLK_DIV);

  logic          s1_q, s2_q, prev_q;
  logic [TW-1:0] tcnt_q;
  logic          fall;

  rstate_e    state_q, state_d;
  logic [3:0] os_q, os_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       bvalid_q, bvalid_d;
  logic       serr_q, serr_d;

  assign tick_o = (tcnt_q == TW'(CLK_DIV - 1));
  assign fall   = prev_q & ~s2_q;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      prev_q   <= 1'b1;
      tcnt_q   <= '0;
      state_q  <= R_IDLE;
      os_q     <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      bvalid_q <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      s1_q     <= rx_i;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      tcnt_q   <= tick_o ? '0 : tcnt_q + TW'(1);
      state_q  <= state_d;
      os_q     <= os_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      bvalid_q <= bvalid_d;
      serr_q   <= serr_d;
    end
  end

  // os counts ticks within the current bit; 8 ticks reach mid-start, 16 ticks per bit after that
  always_comb begin
    state_d  = state_q;
    os_d     = os_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    bvalid_d = 1'b0;
    serr_d   = 1'b0;
    case (state_q)
      R_IDLE: if (fall) begin
        state_d = R_START;
        os_d    = '0;
      end
      R_START: if (tick_o) begin
        os_d = os_q + 4'd1;
        if (os_q == 4'd7) begin
          os_d    = '0;
          bit_d   = '0;
          state_d = s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: if (tick_o) begin
        os_d = os_q + 4'd1;
        if (os_q == 4'd15) begin
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: if (tick_o) begin
        os_d = os_q + 4'd1;
        if (os_q == 4'd15) begin
          if (s2_q) begin
            bvalid_d = 1'b1;
            state_d  = R_IDLE;
          end else begin
            serr_d  = 1'b1;
            state_d = R_WAIT;
          end
        end
      end
      R_WAIT: if (s2_q) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  assign byte_o   = sh_q;
  assign bvalid_o = bvalid_q;
  assign serr_o   = serr_q;
  assign idle_o   = (state_q == R_IDLE);
  assign start_o  = (state_q == R_IDLE) && fall;
endmodule

// File: rtl/frame_rx.sv
// Frame parser AA 0D + 4 payload bytes over uart_rx_byte, with inter-byte timeout.
// rdata/rvalid and rerr/rcode are registered one ck after the byte event; no backpressure.
module frame_rx
  import frame_pkg::*;
#(
  parameter int CLK_DIV = 27,
  parameter int TO_BITS = 20
) (
  input  logic       ck,
  input  logic       rst_n,
  frame_rx_if.slave  bus
);
  localparam int TO_LIM = TO_BITS * 16;
  localparam int TOW    = $clog2(TO_LIM + 1);

  logic [7:0] rx_byte;
  logic       rx_bvalid, rx_serr, rx_idle, rx_start, rx_tick;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .ck       (ck),
    .rst_n    (rst_n),
    .rx_i     (bus.Rx),
    .byte_o   (rx_byte),
    .bvalid_o (rx_bvalid),
    .serr_o   (rx_serr),
    .idle_o   (rx_idle),
    .start_o  (rx_start),
    .tick_o   (rx_tick)
  );

  pstate_e     pst_q, pst_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        rerr_q, rerr_d;
  logic [1:0]  rcode_q, rcode_d;
  logic [TOW-1:0] to_q, to_d;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      pst_q    <= P_HUNT;
      cnt_q    <= '0;
      sh_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rcode_q  <= '0;
      to_q     <= '0;
    end else begin
      pst_q    <= pst_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rcode_q  <= rcode_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    pst_d    = pst_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    rcode_d  = rcode_q;
    to_d     = to_q;

    // Timeout runs only while the line is idle between bytes of a frame in progress
    if (pst_q == P_HUNT || !rx_idle || rx_start)
      to_d = '0;
    else if (rx_tick && to_q != TOW'(TO_LIM))
      to_d = to_q + TOW'(1);

    if (rx_serr) begin
      rerr_d  = 1'b1;
      rcode_d = RC_STOP;
      pst_d   = P_HUNT;
    end else if (rx_bvalid) begin
      case (pst_q)
        P_HUNT: if (rx_byte == HDR0) pst_d = P_HDR;
        P_HDR: begin
          if (rx_byte == HDR1) begin
            pst_d = P_PAY;
            cnt_d = '0;
          end else begin
            rerr_d  = 1'b1;
            rcode_d = RC_HDR;
            if (rx_byte != HDR0) pst_d = P_HUNT;
          end
        end
        P_PAY: begin
          sh_d  = {sh_q[23:0], rx_byte};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(PAYLEN - 1)) begin
            rdata_d  = {sh_q[23:0], rx_byte};
            rvalid_d = 1'b1;
            pst_d    = P_HUNT;
          end
        end
        default: pst_d = P_HUNT;
      endcase
    end else if (pst_q != P_HUNT && to_q == TOW'(TO_LIM)) begin
      rerr_d  = 1'b1;
      rcode_d = RC_TO;
      pst_d   = P_HUNT;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rerr   = rerr_q;
  assign bus.rcode  = rcode_q;
  assign bus.busy   = (pst_q != P_HUNT) || !rx_idle;
endmodule

// File: tb/tb_frame_rx.sv
// Directed bench for frame_rx: byte-level frame model plus per-cycle output compare.
module tb_frame_rx;
  localparam int BT = 64;

  logic ck = 1'b0;
  logic rst_n = 1'b0;
  always #5 ck = ~ck;

  frame_rx_if bus ();

  frame_rx #(.CLK_DIV(4), .TO_BITS(20)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [31:0] data;
  } ev_t;

  int checks = 0;
  int errors = 0;
  ev_t expq[$];
  logic [31:0] exp_rdata = '0;
  logic [1:0]  exp_rcode = '0;
  int nvalid = 0;
  int nerr = 0;

  // frame model: 0 = waiting for AA, 1 = saw AA, 2 = collecting payload
  int m_phase = 0;
  logic [7:0] m_pay[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit is_err, input logic [1:0] code, input logic [31:0] data);
    ev_t e;
    e.is_err = is_err;
    e.code   = code;
    e.data   = data;
    expq.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      push_ev(1'b1, 2'b01, '0);
      m_phase = 0;
      return;
    end
    if (m_phase == 0) begin
      if (b == 8'hAA) m_phase = 1;
    end else if (m_phase == 1) begin
      if (b == 8'h0D) begin
        m_phase = 2;
        m_pay.delete();
      end else begin
        push_ev(1'b1, 2'b10, '0);
        if (b != 8'hAA) m_phase = 0;
      end
    end else begin
      m_pay.push_back(b);
      if (m_pay.size() == 4) begin
        push_ev(1'b0, 2'b00, {m_pay[0], m_pay[1], m_pay[2], m_pay[3]});
        m_phase = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_bit = 1'b1);
    model_byte(b, stop_bit);
    bus.Rx = 1'b0;
    repeat (BT) @(negedge ck);
    for (int i = 0; i < 8; i++) begin
      bus.Rx = b[i];
      repeat (BT) @(negedge ck);
    end
    bus.Rx = stop_bit;
    repeat (BT) @(negedge ck);
    bus.Rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BT) @(negedge ck);
  endtask

  task automatic send_list(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      if (gap > 0) idle_bits(gap);
    end
  endtask

  task automatic drained(input string name);
    repeat (10) @(negedge ck);
    chk(name, expq.size(), 0);
    expq.delete();
  endtask

  // per-cycle compare against the model's expected events and held outputs
  always @(negedge ck) begin
    ev_t e;
    if (rst_n) begin
      chk("excl_pulse", 32'(bus.rvalid & bus.rerr), 0);
      if (bus.rvalid) nvalid++;
      if (bus.rerr) nerr++;
      if (bus.rvalid || bus.rerr) begin
        if (expq.size() == 0) begin
          chk("unexpected_pulse", {30'd0, bus.rvalid, bus.rerr}, 0);
        end else begin
          e = expq.pop_front();
          chk("ev_kind", 32'(bus.rerr), 32'(e.is_err));
          if (e.is_err) exp_rcode = e.code;
          else exp_rdata = e.data;
        end
      end
      chk("rdata_hold", bus.rdata, exp_rdata);
      chk("rcode_hold", 32'(bus.rcode), 32'(exp_rcode));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, cyc;
    logic [7:0] q[$];
    bus.Rx = 1'b1;
    repeat (5) @(negedge ck);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rerr", 32'(bus.rerr), 0);
    chk("rst_rcode", 32'(bus.rcode), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge ck);
    chk("idle_busy", 32'(bus.busy), 0);

    // basic frame with one idle bit between bytes
    v0 = nvalid; e0 = nerr;
    send_byte(8'hAA);
    chk("busy_after_hdr0", 32'(bus.busy), 1);
    idle_bits(1);
    q = '{8'h0D, 8'h12, 8'h34, 8'h56, 8'h78};
    send_list(q, 1);
    drained("t1_drained");
    chk("t1_nvalid", nvalid - v0, 1);
    chk("t1_nerr", nerr - e0, 0);
    chk("t1_rdata", bus.rdata, 32'h12345678);
    chk("t1_busy", 32'(bus.busy), 0);

    // back-to-back bytes, no idle
    v0 = nvalid; e0 = nerr;
    q = '{8'hAA, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00};
    send_list(q, 0);
    drained("t2_drained");
    chk("t2_nvalid", nvalid - v0, 1);
    chk("t2_nerr", nerr - e0, 0);
    chk("t2_rdata", bus.rdata, 32'h00000000);

    // bad header byte, then a good frame
    v0 = nvalid; e0 = nerr;
    q = '{8'hAA, 8'h55};
    send_list(q, 1);
    chk("t3_rcode_hdr", 32'(bus.rcode), 32'h2);
    q = '{8'hAA, 8'h0D, 8'h01, 8'h02, 8'h03, 8'h04};
    send_list(q, 1);
    drained("t3_drained");
    chk("t3_nerr", nerr - e0, 1);
    chk("t3_nvalid", nvalid - v0, 1);
    chk("t3_rdata", bus.rdata, 32'h01020304);

    // repeated AA stays in header state
    v0 = nvalid; e0 = nerr;
    q = '{8'hAA, 8'hAA, 8'h0D, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    send_list(q, 1);
    drained("t4_drained");
    chk("t4_nerr", nerr - e0, 1);
    chk("t4_nvalid", nvalid - v0, 1);
    chk("t4_rdata", bus.rdata, 32'h0A0B0C0D);
    chk("t4_rcode", 32'(bus.rcode), 32'h2);

    // stop error on third payload byte
    v0 = nvalid; e0 = nerr;
    q = '{8'hAA, 8'h0D, 8'h11, 8'h22};
    send_list(q, 1);
    send_byte(8'h33, 1'b0);
    idle_bits(2);
    send_byte(8'h44);
    idle_bits(1);
    drained("t5_drained");
    chk("t5_nerr", nerr - e0, 1);
    chk("t5_nvalid", nvalid - v0, 0);
    chk("t5_rcode", 32'(bus.rcode), 32'h1);
    chk("t5_rdata", bus.rdata, 32'h0A0B0C0D);

    // 3-tick low glitch
    v0 = nvalid; e0 = nerr;
    bus.Rx = 1'b0;
    repeat (12) @(negedge ck);
    bus.Rx = 1'b1;
    idle_bits(4);
    drained("t6_drained");
    chk("t6_nvalid", nvalid - v0, 0);
    chk("t6_nerr", nerr - e0, 0);
    chk("t6_busy", 32'(bus.busy), 0);

    // inter-byte timeout: ~320 ticks after the stop sample (mid-stop), i.e. ~1250 ck after the byte ends
    v0 = nvalid; e0 = nerr;
    q = '{8'hAA, 8'h0D};
    send_list(q, 1);
    send_byte(8'h11);
    push_ev(1'b1, 2'b11, '0);
    m_phase = 0;
    cyc = 0;
    while (cyc < 1600) begin
      @(negedge ck);
      cyc++;
      if (bus.rerr) break;
    end
    chk("t7_latency_in_window", 32'(cyc >= 1240 && cyc <= 1265), 1);
    repeat (25 * BT - cyc) @(negedge ck);
    drained("t7_drained");
    chk("t7_nerr", nerr - e0, 1);
    chk("t7_nvalid", nvalid - v0, 0);
    chk("t7_rcode", 32'(bus.rcode), 32'h3);
    chk("t7_busy", 32'(bus.busy), 0);

    // reset mid-payload
    q = '{8'hAA, 8'h0D, 8'h11};
    send_list(q, 1);
    bus.Rx = 1'b0;
    repeat (3 * BT) @(negedge ck);
    rst_n = 1'b0;
    expq.delete();
    m_phase = 0;
    exp_rdata = '0;
    exp_rcode = '0;
    repeat (3) @(negedge ck);
    chk("t8_rdata", bus.rdata, 0);
    chk("t8_rvalid", 32'(bus.rvalid), 0);
    chk("t8_rerr", 32'(bus.rerr), 0);
    chk("t8_rcode", 32'(bus.rcode), 0);
    chk("t8_busy", 32'(bus.busy), 0);
    bus.Rx = 1'b1;
    repeat (5) @(negedge ck);
    v0 = nvalid; e0 = nerr;
    rst_n = 1'b1;
    idle_bits(12);
    chk("t8_post_nvalid", nvalid - v0, 0);
    chk("t8_post_nerr", nerr - e0, 0);
    chk("t8_post_rdata", bus.rdata, 0);
    chk("t8_post_busy", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_rx.md
FRAME_RX -- requirements
Module: frame_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27, meaning ck cycles per 1/16-bit oversample tick (range 2..4095).
REQ-002 SHALL have parameter TO_BITS, default 20, meaning the inter-byte timeout in bit times while a frame is in progress.
REQ-003 SHALL have port ck  input  1  system clock; the block uses one clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Rx  input  1  asynchronous serial line; idle high; start 0, 8 data bits LSB first, stop 1.
REQ-006 SHALL have port rdata  output  32  payload of the last good frame; first payload byte in [31:24].
REQ-007 SHALL have port rvalid  output  1  one-ck pulse when rdata is updated.
REQ-008 SHALL have port rerr  output  1  one-ck error pulse.
REQ-009 SHALL have port rcode  output  2  error code, valid with rerr: 01 stop error, 10 header mismatch, 11 timeout; held until the next rerr.
REQ-010 SHALL have port busy  output  1  high while the parser is not in HUNT or a byte is being received.

Function
REQ-011 SHALL synchronise Rx through 2 flops (reset value 1) before any use.
REQ-012 SHALL generate an oversample tick every CLK_DIV ck cycles; the tick counter is free-running.
REQ-013 Byte receiver SHALL leave IDLE on a synchronised 1->0 edge, recheck the line at tick 8 (mid-start), and return to IDLE with no byte and no error if the line is high.
REQ-014 SHALL then sample 8 data bits at 16-tick intervals from mid-start, LSB first, then the stop bit 16 ticks later.
REQ-015 If the stop sample is 1, SHALL emit the byte to the parser one ck after the stop sample, then re-arm IDLE immediately; a new start edge during the stop bit's second half SHALL be accepted.
REQ-016 If the stop sample is 0, SHALL discard the byte, pulse rerr with rcode=01, force the parser to HUNT, and wait for the line high before re-arming.
REQ-017 Parser states SHALL be HUNT, HDR, PAY.
REQ-018 In HUNT, byte 8'hAA SHALL move to HDR; any other byte SHALL be ignored silently.
REQ-019 In HDR, byte 8'h0D SHALL move to PAY with the payload count 0; 8'hAA SHALL pulse rcode=10 and stay in HDR; any other byte SHALL pulse rcode=10 and return to HUNT.
REQ-020 In PAY, bytes SHALL shift into a 32-bit register MSB-byte first.
REQ-021 On the 4th payload byte, SHALL load rdata in the same ck, pulse rvalid, and return to HUNT.
REQ-022 rdata SHALL hold between frames; error and aborted frames SHALL leave rdata unchanged.
REQ-023 In HDR/PAY, if no start edge occurs within TO_BITS*16 ticks after the previous stop sample, SHALL pulse rcode=11 and return to HUNT.
REQ-024 The timeout counter SHALL saturate and SHALL NOT count in HUNT.
REQ-025 rvalid and rerr SHALL never be high in the same cycle.

Reset
REQ-026 rst_n low SHALL asynchronously clear rdata, rvalid, rerr, rcode and busy to 0, set both sync flops to 1, and put the receiver in IDLE and the parser in HUNT.
REQ-027 Tick, bit and timeout counters SHALL reset to 0.
REQ-028 Assertion of rst_n mid-frame SHALL discard partial data with no pulse on release.

Structure
REQ-029 Package frame_pkg SHALL hold HDR0=8'hAA, HDR1=8'h0D, PAYLEN=4, the rcode constants, and the parser state encoding.
REQ-030 Sub-module uart_rx_byte SHALL contain the synchroniser, tick generator and byte receiver, with outputs byte[7:0], bvalid, serr, idle and start.
REQ-031 frame_rx SHALL contain the parser and timeout logic.

Verification
REQ-032 Run the bench with CLK_DIV=4 and bit time = 64 ck.
REQ-033 Bytes AA 0D 12 34 56 78 -> exactly one rvalid; rdata=32'h12345678; no rerr.
REQ-034 Bytes AA 0D 00 00 00 00 sent back-to-back with no idle -> rvalid; rdata=32'h00000000.
REQ-035 AA 55, then AA 0D 01 02 03 04 -> rerr with rcode=10 on 55; then rvalid with rdata=32'h01020304.
REQ-036 AA AA 0D 0A 0B 0C 0D -> one rerr with rcode=10; then rvalid with rdata=32'h0A0B0C0D.
REQ-037 Stop bit forced 0 on the 3rd payload byte -> rerr with rcode=01; no rvalid; rdata unchanged.
REQ-038 A 3-tick low glitch on idle Rx -> no byte and no rerr.
REQ-039 AA 0D 11 followed by 25 bit times of idle -> rerr with rcode=11 after 320 ticks.
REQ-040 rst_n pulsed low mid-payload -> all outputs 0 and no pulse after release.
